alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Parametrised alarm controller for the digital-clock design. It drives the active-low LED and buzzer from two alarm sources: the countdown-reached-zero flag from the time counters, and an over-temperature comparison with hysteresis. It adds several behaviours:
- programmable ring duration
- pulsed beep pattern
- operator acknowledge
- a hold state that keeps the LED lit while over-temperature persists

## Interface
Parameters:
- CLK_FREQ, 50_000_000 — clk frequency in Hz
- ALARM_SEC, 3 — ring duration in seconds; DUR_CYC = CLK_FREQ*ALARM_SEC
- BEEP_MS, 250 — buzzer on/off half-period in ms; BEEP_CYC = CLK_FREQ/1000*BEEP_MS, minimum 1
- TEMP_W, 24 — temperature word width
- TEMP_HI, 300000 — over-temperature set threshold, inclusive
- TEMP_LO, 290000 — over-temperature clear threshold; requires TEMP_LO <= TEMP_HI

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- temp  in  TEMP_W  unsigned temperature sample, synchronous to clk
- time_zero  in  1  high while all countdown digits are zero (level)
- ack  in  1  single-cycle operator acknowledge, synchronous
- led  out  1  alarm LED, active low
- buzzer  out  1  buzzer drive, active low
- active  out  1  high in RING or HOLD
- cause  out  2  bit0 = countdown source, bit1 = temperature source; sticky until return to IDLE

## Operation
Registers:
- tz_d: previous time_zero.
- ot (over-temp flag):
  - set when temp >= TEMP_HI
  - cleared when temp < TEMP_LO
  - otherwise held
- ot_d: previous ot.

Events:
- tz_rise = time_zero & ~tz_d
- ot_rise = ot & ~ot_d

FSM states:
- IDLE: led=1, buzzer=1, active=0, cause=0.
  - Either event → RING.
  - Clear dur_cnt and beep_cnt; beep phase = on.
  - cause |= {ot_rise, tz_rise}.
- RING: led=0, active=1; buzzer=0 in on-phase, 1 in off-phase.
  - beep_cnt counts 0..BEEP_CYC-1; at wrap the phase toggles.
  - dur_cnt counts 0..DUR_CYC-1.
  - New event in RING: dur_cnt, beep_cnt and phase restart; cause ORs the new bit.
  - Exit on ack, or on dur_cnt == DUR_CYC-1: → HOLD if ot=1, else → IDLE.
  - Event and exit in the same cycle: the event wins (restart, stay in RING).
- HOLD: led=0, buzzer=1, active=1.
  - ot=0 → IDLE.
  - tz_rise → RING (restart counters, cause |= 01).
  - ack is ignored.
- ack in IDLE is ignored.

Arithmetic and width rules:
- Counter widths are $clog2 of their terminal counts.
- Counters stop and clear outside RING.
- Temperature compares are unsigned.
- A stuck-high time_zero produces exactly one ring; it re-arms only after time_zero drops.

## Timing
Reset values:
- led=1, buzzer=1, active=0, cause=0
- state IDLE, counters 0
- tz_d=1 and ot=0, ot_d=0
- tz_d=1 at reset means time_zero already high at reset release does not ring.

Latency:
- time_zero rising at edge k-sampled input → led/buzzer low after edge k.
- temp crossing TEMP_HI → ot set at edge k → led/buzzer low after edge k+1 (2-cycle latency).
- Ring length without ack: buzzer/led active exactly DUR_CYC cycles.
- ack sampled at edge k → outputs update after edge k.

Other timing rules:
- Buzzer waveform starts on-phase: low for BEEP_CYC cycles, high for BEEP_CYC, repeating. A truncated final phase is allowed.
- All outputs are registered; no combinational input-to-output path.
- rst_n assertion mid-ring forces the reset values immediately, asynchronously.

## Test plan
Bench parameters: CLK_FREQ=1000, ALARM_SEC=3, BEEP_MS=100, TEMP_HI=300000, TEMP_LO=290000.

1. **Countdown alarm.** Raise time_zero and hold it high.
   - led=0 for exactly 3000 cycles; cause=01.
   - buzzer toggles every 100 cycles, starting low.
   - Then IDLE, with no re-ring while time_zero stays high.
2. **Acknowledge.** tz_rise, then ack at cycle 450.
   - led/buzzer return to 1 after that edge; active=0.
   - A second ack in IDLE has no effect.
3. **Temperature hysteresis.** temp 0 → 300000.
   - Ring starts 2 cycles later with cause=10; after 3000 cycles → HOLD (led=0, buzzer=1).
   - temp → 295000: stays in HOLD.
   - temp → 289999: IDLE.
4. **Retrigger.** In RING at dur_cnt=2000, pulse time_zero low then high.
   - Duration restarts; total ring = 2000 + 1 + 3000 cycles.
   - Buzzer phase restarts low.
5. **Simultaneous events.** tz_rise on the same cycle as ack, and on the terminal dur_cnt cycle.
   - Stays in RING with counters restarted.
6. **Reset mid-ring.** Assert rst_n=0 at cycle 1000 of a ring.
   - led=1, buzzer=1, active=0, cause=0 immediately.
   - After release with time_zero already high: no ring.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: drives the active-low alarm LED and buzzer from two sources,
// the countdown-reached-zero flag and an over-temperature flag with
// hysteresis. A ring lasts a programmable time with a pulsed beep, can be
// acknowledged by the operator, and falls into a hold state (LED lit,
// buzzer quiet) while the over-temperature condition persists.
module alarm_ctrl #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int ALARM_SEC = 3,
    parameter int BEEP_MS   = 250,
    parameter int TEMP_W    = 24,
    parameter int TEMP_HI   = 300000,
    parameter int TEMP_LO   = 290000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temp,
    input  logic              time_zero,
    input  logic              ack,
    output logic              led,
    output logic              buzzer,
    output logic              active,
    output logic [1:0]        cause
);

    // Ring length and beep half-period in clock cycles; the beep half-period
    // never drops below one cycle even for very slow clocks.
    localparam int DUR_CYC  = CLK_FREQ * ALARM_SEC;
    localparam int BEEP_RAW = (CLK_FREQ / 1000) * BEEP_MS;
    localparam int BEEP_CYC = (BEEP_RAW < 1) ? 1 : BEEP_RAW;

    localparam int DUR_W  = (DUR_CYC > 1) ? $clog2(DUR_CYC) : 1;
    localparam int BEEP_W = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

    localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(DUR_CYC - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYC - 1);

    localparam logic [TEMP_W-1:0] TEMP_HI_T = TEMP_W'(TEMP_HI);
    localparam logic [TEMP_W-1:0] TEMP_LO_T = TEMP_W'(TEMP_LO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RING = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [DUR_W-1:0]   dur_cnt;
    logic [DUR_W-1:0]   dur_n;
    logic [BEEP_W-1:0]  beep_cnt;
    logic [BEEP_W-1:0]  beep_n;
    logic               phase_on;
    logic               phase_n;
    logic [1:0]         cause_n;
    logic               led_n;
    logic               buzzer_n;
    logic               active_n;

    logic               tz_d;
    logic               ot;
    logic               ot_d;
    logic               tz_rise;
    logic               ot_rise;

    // tz_d resets high so a time_zero already high at reset release is not
    // mistaken for a fresh countdown expiry.
    assign tz_rise = time_zero & ~tz_d;
    assign ot_rise = ot & ~ot_d;

    // Input history and the hysteresis over-temperature flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tz_d <= 1'b1;
            ot   <= 1'b0;
            ot_d <= 1'b0;
        end else begin
            tz_d <= time_zero;
            ot_d <= ot;
            if (temp >= TEMP_HI_T) begin
                ot <= 1'b1;
            end else if (temp < TEMP_LO_T) begin
                ot <= 1'b0;
            end
        end
    end

    // Next state, counters, cause and output values; a new event always
    // beats an exit request in the same cycle.
    always_comb begin
        state_n  = state;
        dur_n    = '0;
        beep_n   = '0;
        phase_n  = 1'b1;
        cause_n  = cause;

        case (state)
            IDLE: begin
                cause_n = 2'b00;
                if (tz_rise || ot_rise) begin
                    state_n = RING;
                    cause_n = {ot_rise, tz_rise};
                end
            end

            RING: begin
                if (tz_rise || ot_rise) begin
                    cause_n = cause | {ot_rise, tz_rise};
                end else if (ack || (dur_cnt == DUR_LAST)) begin
                    if (ot) begin
                        state_n = HOLD;
                    end else begin
                        state_n = IDLE;
                        cause_n = 2'b00;
                    end
                end else begin
                    dur_n = dur_cnt + 1'b1;
                    if (beep_cnt == BEEP_LAST) begin
                        beep_n  = '0;
                        phase_n = ~phase_on;
                    end else begin
                        beep_n  = beep_cnt + 1'b1;
                        phase_n = phase_on;
                    end
                end
            end

            HOLD: begin
                if (tz_rise) begin
                    state_n = RING;
                    cause_n = cause | 2'b01;
                end else if (!ot) begin
                    state_n = IDLE;
                    cause_n = 2'b00;
                end
            end

            default: begin
                state_n = IDLE;
                cause_n = 2'b00;
            end
        endcase

        led_n    = (state_n == IDLE);
        buzzer_n = ~((state_n == RING) && phase_n);
        active_n = (state_n != IDLE);
    end

    // State, counters and registered outputs; reset forces the idle values
    // immediately, even in the middle of a ring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            beep_cnt <= '0;
            phase_on <= 1'b1;
            cause    <= 2'b00;
            led      <= 1'b1;
            buzzer   <= 1'b1;
            active   <= 1'b0;
        end else begin
            state    <= state_n;
            dur_cnt  <= dur_n;
            beep_cnt <= beep_n;
            phase_on <= phase_n;
            cause    <= cause_n;
            led      <= led_n;
            buzzer   <= buzzer_n;
            active   <= active_n;
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed bench for alarm_ctrl with a 1 kHz clock, 3 s rings
// and 100-cycle beep half-periods. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active edge.
module tb_alarm_ctrl;

    localparam int DUR    = 3000;
    localparam int BEEP   = 100;
    localparam logic [23:0] T_COLD = 24'd0;
    localparam logic [23:0] T_HOT  = 24'd300000;
    localparam logic [23:0] T_MID  = 24'd295000;
    localparam logic [23:0] T_COOL = 24'd289999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] temp;
    logic        time_zero;
    logic        ack;
    logic        led;
    logic        buzzer;
    logic        active;
    logic [1:0]  cause;

    int checks = 0;
    int errors = 0;
    int lows;

    alarm_ctrl #(
        .CLK_FREQ (1000),
        .ALARM_SEC(3),
        .BEEP_MS  (100),
        .TEMP_W   (24),
        .TEMP_HI  (300000),
        .TEMP_LO  (290000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .temp     (temp),
        .time_zero(time_zero),
        .ack      (ack),
        .led      (led),
        .buzzer   (buzzer),
        .active   (active),
        .cause    (cause)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Safety net in case the run ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic tz, input logic a, input logic [23:0] t);
        time_zero = tz;
        ack       = a;
        temp      = t;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_led"},    led,    1'b1);
        checkOutput({tag, "_buzzer"}, buzzer, 1'b1);
        checkOutput({tag, "_active"}, active, 1'b0);
        checkOutput({tag, "_cause"},  cause,  2'b00);
    endtask

    task automatic checkHold(input string tag, input logic [1:0] c);
        checkOutput({tag, "_led"},    led,    1'b0);
        checkOutput({tag, "_buzzer"}, buzzer, 1'b1);
        checkOutput({tag, "_active"}, active, 1'b1);
        checkOutput({tag, "_cause"},  cause,  c);
    endtask

    // Walks n ring cycles starting at ring index start, checking the LED,
    // active flag and the beep square wave; reports the number of bad cycles.
    task automatic ringPattern(input string tag, input int start, input int n);
        int   bad;
        int   idx;
        logic exp_b;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            idx   = start + i;
            exp_b = ((idx / BEEP) % 2) != 0;
            if (led !== 1'b0 || active !== 1'b1 || buzzer !== exp_b) bad++;
            @(negedge clk);
        end
        checkOutput({tag, "_bad_cycles"}, bad, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, T_COLD);
        #12;
        checkIdle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        checkIdle("post_reset");

        // Countdown alarm with time_zero held high.
        $display("[TB] countdown alarm");
        applyStimulus(1'b1, 1'b0, T_COLD);
        tick(1);
        checkOutput("t1_cause", cause, 2'b01);
        ringPattern("t1_ring", 0, DUR);
        checkIdle("t1_end");
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (led !== 1'b1) lows++;
            @(negedge clk);
        end
        checkOutput("t1_no_rering", lows, 0);

        // Acknowledge mid-ring, then a stray ack in idle.
        $display("[TB] acknowledge");
        applyStimulus(1'b0, 1'b0, T_COLD);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_COLD);
        tick(1);
        checkOutput("t2_cause", cause, 2'b01);
        ringPattern("t2_ring", 0, 449);
        checkOutput("t2_buzzer_pre_ack", buzzer, 1'b0);
        applyStimulus(1'b1, 1'b1, T_COLD);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_COLD);
        checkIdle("t2_ack");
        applyStimulus(1'b1, 1'b1, T_COLD);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_COLD);
        tick(1);
        checkIdle("t2_ack_idle");

        // Over-temperature ring, hold, hysteresis and tz re-ring from hold.
        $display("[TB] temperature");
        applyStimulus(1'b1, 1'b0, T_HOT);
        tick(1);
        checkOutput("t3_not_yet", led, 1'b1);
        tick(1);
        checkOutput("t3_cause", cause, 2'b10);
        ringPattern("t3_ring", 0, DUR);
        checkHold("t3_hold", 2'b10);
        applyStimulus(1'b1, 1'b0, T_MID);
        tick(50);
        checkHold("t3_hyst", 2'b10);
        applyStimulus(1'b1, 1'b1, T_MID);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_MID);
        tick(1);
        checkHold("t3_ack_hold", 2'b10);
        applyStimulus(1'b0, 1'b0, T_MID);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_MID);
        tick(1);
        checkOutput("t3_both_cause", cause, 2'b11);
        ringPattern("t3_ring2", 0, DUR);
        checkHold("t3_hold2", 2'b11);
        applyStimulus(1'b1, 1'b0, T_COOL);
        tick(1);
        checkOutput("t3_hold_lag", led, 1'b0);
        tick(1);
        checkIdle("t3_clear");

        // Retrigger at dur_cnt 2000: 2001 cycles, then a fresh full ring.
        $display("[TB] retrigger");
        applyStimulus(1'b0, 1'b0, T_COOL);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_COOL);
        tick(1);
        ringPattern("t4_pre", 0, 1999);
        applyStimulus(1'b0, 1'b0, T_COOL);
        ringPattern("t4_low", 1999, 1);
        applyStimulus(1'b1, 1'b0, T_COOL);
        ringPattern("t4_rise", 2000, 1);
        ringPattern("t4_restart", 0, DUR);
        checkIdle("t4_end");

        // Event together with ack, then event on the terminal cycle.
        $display("[TB] simultaneous events");
        applyStimulus(1'b0, 1'b0, T_COOL);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_COOL);
        tick(1);
        ringPattern("t5_pre", 0, 299);
        applyStimulus(1'b0, 1'b0, T_COOL);
        ringPattern("t5_low", 299, 1);
        applyStimulus(1'b1, 1'b1, T_COOL);
        ringPattern("t5_ack_rise", 300, 1);
        applyStimulus(1'b1, 1'b0, T_COOL);
        checkOutput("t5_cause", cause, 2'b01);
        ringPattern("t5_after_ack", 0, 2998);
        applyStimulus(1'b0, 1'b0, T_COOL);
        ringPattern("t5_low2", 2998, 1);
        applyStimulus(1'b1, 1'b0, T_COOL);
        ringPattern("t5_term_rise", 2999, 1);
        ringPattern("t5_restart", 0, DUR);
        checkIdle("t5_end");

        // Asynchronous reset mid-ring, release with time_zero already high.
        $display("[TB] reset mid-ring");
        applyStimulus(1'b0, 1'b0, T_COOL);
        tick(1);
        applyStimulus(1'b1, 1'b0, T_COOL);
        tick(1);
        ringPattern("t6_ring", 0, 1000);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("t6_async");
        tick(3);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (led !== 1'b1 || active !== 1'b0) lows++;
            @(negedge clk);
        end
        checkOutput("t6_no_ring", lows, 0);
        checkIdle("t6_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
